// File: rtl/serial_pkg.sv
// rtl/serial_pkg.sv - shared types and defaults for the serial shift controllers
package serial_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2,
    DONE  = 2'd3
  } cap_state_t;

  localparam int SERIAL_WIDTH_DEFAULT = 8;

endpackage

// File: rtl/shift_reg_in.sv
// rtl/shift_reg_in.sv - serial-in parallel-out shift register with selectable entry end
module shift_reg_in #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Shift_En,
  input  logic             Din,
  output logic [WIDTH-1:0] Data_Out
);

  // LSB-first frames enter at the MSB and walk down so bit 0 ends in Data_Out[0]
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      Data_Out <= '0;
    end else if (Shift_En) begin
      if (MSB_FIRST) Data_Out <= {Data_Out[WIDTH-2:0], Din};
      else           Data_Out <= {Din, Data_Out[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/serial_capture_ctrl.sv
// rtl/serial_capture_ctrl.sv - captures a WIDTH-bit serial frame per Execute pulse, Valid/Ready output
module serial_capture_ctrl
  import serial_pkg::*;
#(
  parameter int WIDTH     = SERIAL_WIDTH_DEFAULT,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Execute,
  input  logic             Din,
  input  logic             Ready,
  output logic [WIDTH-1:0] Dout,
  output logic             Valid,
  output logic             Busy
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  cap_state_t       state, state_nxt;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] shift_q;
  logic [WIDTH-1:0] word_nxt;
  logic             shift_en;
  logic             last_bit;
  logic             load_word;
  logic             accept;

  shift_reg_in #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_shift (
    .Clk      (Clk),
    .Reset    (Reset),
    .Shift_En (shift_en),
    .Din      (Din),
    .Data_Out (shift_q)
  );

  assign last_bit = (count == LAST);

  // Final bit is folded in here so Dout loads the whole frame on the same edge
  assign word_nxt = MSB_FIRST ? {shift_q[WIDTH-2:0], Din} : {Din, shift_q[WIDTH-1:1]};

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    shift_en  = 1'b0;
    load_word = 1'b0;
    accept    = 1'b0;
    Busy      = 1'b0;
    case (state)
      IDLE: begin
        if (Execute) state_nxt = SHIFT;
      end
      SHIFT: begin
        Busy     = 1'b1;
        shift_en = 1'b1;
        if (last_bit) begin
          load_word = 1'b1;
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (Valid && Ready) begin
          accept    = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (!Execute) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset)        count <= '0;
    else if (shift_en) count <= count + 1'b1;
    else               count <= '0;
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      Dout  <= '0;
      Valid <= 1'b0;
    end else if (load_word) begin
      Dout  <= word_nxt;
      Valid <= 1'b1;
    end else if (accept) begin
      Valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_serial_capture_ctrl.sv
// tb/tb_serial_capture_ctrl.sv - scoreboard bench driving LSB-first and MSB-first captures in parallel
module tb_serial_capture_ctrl;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       Execute;
  logic       Din;
  logic       Ready;
  logic [7:0] dout_l, dout_m;
  logic       valid_l, valid_m;
  logic       busy_l, busy_m;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [7:0] q_l[$];
  logic [7:0] q_m[$];
  logic [7:0] hold_l, hold_m, e_l, e_m;
  logic       prev_l = 1'b0;
  logic       prev_m = 1'b0;

  always #5 Clk = ~Clk;

  serial_capture_ctrl #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
    .Clk(Clk), .Reset(Reset), .Execute(Execute), .Din(Din), .Ready(Ready),
    .Dout(dout_l), .Valid(valid_l), .Busy(busy_l)
  );

  serial_capture_ctrl #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
    .Clk(Clk), .Reset(Reset), .Execute(Execute), .Din(Din), .Ready(Ready),
    .Dout(dout_m), .Valid(valid_m), .Busy(busy_m)
  );

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // Monitor: each rising Valid pops one expected word; Dout must then hold steady
  always @(negedge Clk) begin
    if (valid_l && !prev_l) begin
      if (q_l.size() == 0) check("lsb_unexpected_frame", 32'(dout_l), 32'hFFFF_FFFF);
      else begin
        e_l = q_l.pop_front();
        check("lsb_dout", 32'(dout_l), 32'(e_l));
      end
      hold_l = dout_l;
    end else if (valid_l && prev_l) begin
      check("lsb_dout_stable", 32'(dout_l), 32'(hold_l));
    end
    prev_l = valid_l;
  end

  always @(negedge Clk) begin
    if (valid_m && !prev_m) begin
      if (q_m.size() == 0) check("msb_unexpected_frame", 32'(dout_m), 32'hFFFF_FFFF);
      else begin
        e_m = q_m.pop_front();
        check("msb_dout", 32'(dout_m), 32'(e_m));
      end
      hold_m = dout_m;
    end else if (valid_m && prev_m) begin
      check("msb_dout_stable", 32'(dout_m), 32'(hold_m));
    end
    prev_m = valid_m;
  end

  // b[i] is the i-th bit on the wire; drop_at < 0 keeps Execute high throughout
  task automatic frame(input logic [7:0] b, input logic [7:0] el, input logic [7:0] em,
                       input int drop_at);
    q_l.push_back(el);
    q_m.push_back(em);
    @(negedge Clk);
    Execute = 1'b1;
    Din     = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge Clk);
      check("busy_shift", 32'(busy_l), 32'd1);
      check("valid_low_in_shift", 32'(valid_l), 32'd0);
      Din = b[i];
      if (i == drop_at) Execute = 1'b0;
    end
    @(negedge Clk);
    check("valid_latency_lsb", 32'(valid_l), 32'd1);
    check("valid_latency_msb", 32'(valid_m), 32'd1);
    check("busy_low_hold", 32'(busy_l), 32'd0);
  endtask

  task automatic accept();
    Ready = 1'b1;
    @(negedge Clk);
    check("valid_cleared_lsb", 32'(valid_l), 32'd0);
    check("valid_cleared_msb", 32'(valid_m), 32'd0);
    Ready = 1'b0;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    Reset   = 1'b0;
    Execute = 1'b0;
    Din     = 1'b0;
    Ready   = 1'b0;
    #1;
    check("reset_valid_lsb", 32'(valid_l), 32'd0);
    check("reset_valid_msb", 32'(valid_m), 32'd0);
    check("reset_busy", 32'(busy_l), 32'd0);
    check("reset_dout_lsb", 32'(dout_l), 32'd0);
    check("reset_dout_msb", 32'(dout_m), 32'd0);
    @(negedge Clk);
    Reset = 1'b1;

    // Stream 1,0,1,1,0,0,1,0 with a one-cycle Execute
    frame(8'h4D, 8'h4D, 8'hB2, 0);
    accept();

    // Consumer stalls for 20 cycles
    frame(8'hF0, 8'hF0, 8'h0F, 0);
    for (int i = 0; i < 20; i++) begin
      @(negedge Clk);
      check("stall_valid_lsb", 32'(valid_l), 32'd1);
      check("stall_valid_msb", 32'(valid_m), 32'd1);
      check("stall_busy", 32'(busy_l), 32'd0);
    end
    accept();

    // Execute held high: second frame ignored until Execute drops
    frame(8'h96, 8'h96, 8'h69, -1);
    accept();
    for (int i = 0; i < 10; i++) begin
      @(negedge Clk);
      check("held_exec_busy", 32'(busy_l), 32'd0);
      check("held_exec_valid", 32'(valid_l), 32'd0);
      check("held_exec_dout", 32'(dout_l), 32'h96);
      Din = i[0];
    end
    Execute = 1'b0;
    @(negedge Clk);
    frame(8'h4D, 8'h4D, 8'hB2, 0);
    accept();

    // Execute drops after 2 bits; Ready already high before Valid rises
    Ready = 1'b1;
    frame(8'h83, 8'h83, 8'hC1, 2);
    @(negedge Clk);
    check("early_ready_release", 32'(valid_l), 32'd0);
    Ready = 1'b0;

    // Reset after 4 bits of SHIFT
    @(negedge Clk);
    Execute = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge Clk);
      Execute = 1'b0;
      Din     = 1'b1;
    end
    #2 Reset = 1'b0;
    #1;
    check("midshift_reset_busy", 32'(busy_l), 32'd0);
    check("midshift_reset_valid", 32'(valid_l), 32'd0);
    check("midshift_reset_dout_lsb", 32'(dout_l), 32'd0);
    check("midshift_reset_dout_msb", 32'(dout_m), 32'd0);
    @(negedge Clk);
    Reset = 1'b1;
    frame(8'hFF, 8'hFF, 8'hFF, 0);
    accept();

    // Reset while holding an unaccepted frame
    frame(8'h4D, 8'h4D, 8'hB2, 0);
    #2 Reset = 1'b0;
    #1;
    check("hold_reset_valid_lsb", 32'(valid_l), 32'd0);
    check("hold_reset_valid_msb", 32'(valid_m), 32'd0);
    check("hold_reset_dout", 32'(dout_l), 32'd0);
    @(negedge Clk);
    Reset = 1'b1;

    repeat (3) @(negedge Clk);
    check("queue_empty_lsb", 32'(q_l.size()), 32'd0);
    check("queue_empty_msb", 32'(q_m.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
